serial_frame_rx: RTL and testbench

- Receiver stage directly downstream of the team's serial-in/serial-out shift register; consumes its 1-bit serial output stream.
- Detects a framed word (start bit, N data bits LSB-first, optional parity, stop bit) and converts it to a parallel word.
- Presents the word on a valid/ready handshake to parallel consumers.
- Flags parity errors, framing errors and overruns.

---
 rtl/serial_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_serial_frame_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial-to-parallel receiver.
// Samples sin on bit_en strobes, assembles start/data/parity/stop frames
// (data LSB first), and presents each word on a valid/ready interface.
// Reports parity status with the word, and pulses on framing errors and overruns.
module serial_frame_rx #(
  parameter int N          = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         bit_en,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         parity_err,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Expected parity bit for a data word: XOR of all bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [N-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [N-1:0]   shift_r, shift_s;
  logic           par_bit_r, par_bit_s;
  logic           stop_edge_s;
  logic           good_s, bad_s, load_s, drop_s;
  logic           perr_s;
  logic           valid_s;

  logic [N-1:0]   dout_r;
  logic           dout_valid_r;
  logic           parity_err_r;
  logic           frame_err_r;
  logic           overrun_r;
  logic           busy_r;

  // Frame sequencing: next state, bit counter, data shift and parity capture.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    shift_s     = shift_r;
    par_bit_s   = par_bit_r;
    stop_edge_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bit_en && sin) begin
          state_s = DATA;
          cnt_s   = '0;
          shift_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      DATA: begin
        if (bit_en) begin
          for (int i = 0; i < N; i++) begin
            if (cnt_r == CW'(i)) begin
              shift_s[i] = sin;
            end else begin
              shift_s[i] = shift_r[i];
            end
          end
          cnt_s = cnt_r + CW'(1);
          if (cnt_r == CW'(N - 1)) begin
            state_s = PARITY_EN ? PARITY : STOP;
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_en) begin
          par_bit_s = sin;
          state_s   = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_en) begin
          stop_edge_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        shift_s = '0;
      end
    endcase
  end

  // Output delivery: decide load, drop and handshake clearing on a stop edge.
  always_comb begin
    good_s = stop_edge_s && !sin;
    bad_s  = stop_edge_s && sin;
    load_s = good_s && (!dout_valid_r || dout_ready);
    drop_s = good_s && dout_valid_r && !dout_ready;
    if (PARITY_EN) begin
      perr_s = calc_parity(shift_r, PARITY_ODD) != par_bit_r;
    end else begin
      perr_s = 1'b0;
    end
    if (load_s) begin
      valid_s = 1'b1;
    end else if (dout_valid_r && dout_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = dout_valid_r;
    end
  end

  // Receiver state, counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      shift_r   <= '0;
      par_bit_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      shift_r   <= shift_s;
      par_bit_r <= par_bit_s;
    end
  end

  // Registered outputs: held word, valid flag, status and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (load_s) begin
        dout_r       <= shift_r;
        parity_err_r <= perr_s;
      end
      dout_valid_r <= valid_s;
      frame_err_r  <= bad_s;
      overrun_r    <= drop_s;
      busy_r       <= (state_s != IDLE);
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed frames with a scoreboard of expected words.
// Stimulus pushes {parity_err, dout} for each word that must be delivered;
// a monitor pops and compares on every transfer and tallies error pulses.
module tb_serial_frame_rx;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       bit_en;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic prev_fe = 1'b0;
  logic prev_ov = 1'b0;
  logic [4:0] exp_q[$];

  serial_frame_rx #(.N(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .bit_en     (bit_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare transfers against the scoreboard and tally error pulses.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!rst && dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", dout);
        end else begin
          e = exp_q.pop_front();
          chk("word_dout", {4'h0, dout}, {4'h0, e[3:0]});
          chk("word_perr", {7'h0, parity_err}, {7'h0, e[4]});
        end
      end
      if (frame_err || overrun) begin
        chk("pulse_exclusive", {7'h0, frame_err & overrun}, 8'h00);
        chk("pulse_width", {6'h0, prev_fe & frame_err, prev_ov & overrun}, 8'h00);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      prev_fe = frame_err;
      prev_ov = overrun;
    end
  end

  // One sample cycle; inputs change 2 time units after the rising edge.
  task automatic drive(input logic s, input logic en);
    sin    = s;
    bit_en = en;
    @(posedge clk);
    #2;
  endtask

  // Full frame: start, 4 data bits LSB first, parity, stop; gap idle cycles
  // between strobes with sin toggling to model glitches.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                            input int gap, input bit deliver);
    logic [6:0] bits;
    bits = {s, p, d, 1'b1};
    if (deliver) exp_q.push_back({p ^ (^d), d});
    for (int i = 0; i < 7; i++) begin
      drive(bits[i], 1'b1);
      for (int g = 0; g < gap; g++) drive(~sin, 1'b0);
    end
    sin    = 1'b0;
    bit_en = 1'b0;
  endtask

  // Directed stimulus.
  initial begin
    rst        = 1'b1;
    sin        = 1'b0;
    bit_en     = 1'b0;
    dout_ready = 1'b1;
    #23;
    @(posedge clk);
    #2;
    chk("rst_dout", {4'h0, dout}, 8'h00);
    chk("rst_flags", {3'h0, dout_valid, parity_err, frame_err, overrun, busy}, 8'h00);
    rst = 1'b0;

    // Idle line: nothing must happen.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1);
      chk("idle_flags", {3'h0, dout_valid, parity_err, frame_err, overrun, busy}, 8'h00);
    end

    // Good frame 0xA, correct even parity; one cycle of valid.
    send_frame(4'hA, 1'b0, 1'b0, 0, 1'b1);
    chk("a_latency_valid", {7'h0, dout_valid}, 8'h01);
    chk("a_latency_dout", {4'h0, dout}, 8'h0A);
    drive(1'b0, 1'b0);
    chk("a_valid_one_cycle", {7'h0, dout_valid}, 8'h00);

    // Same word, wrong parity bit.
    send_frame(4'hA, 1'b1, 1'b0, 0, 1'b1);
    chk("a_perr_valid", {7'h0, parity_err}, 8'h01);
    drive(1'b0, 1'b0);

    // Bad stop bit: frame error, no word.
    send_frame(4'hA, 1'b0, 1'b1, 0, 1'b0);
    chk("fe_pulse", {7'h0, frame_err}, 8'h01);
    chk("fe_no_valid", {7'h0, dout_valid}, 8'h00);
    drive(1'b0, 1'b0);
    chk("fe_cleared", {6'h0, frame_err, dout_valid}, 8'h00);

    // Back-to-back 0x3 then 0x5 with consumer stalled: 0x5 overruns.
    dout_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b0, 0, 1'b1);
    send_frame(4'h5, 1'b0, 1'b0, 0, 1'b0);
    chk("ov_pulse", {7'h0, overrun}, 8'h01);
    chk("ov_held_dout", {4'h0, dout}, 8'h03);
    chk("ov_held_valid", {6'h0, dout_valid, parity_err}, 8'h02);
    drive(1'b0, 1'b0);
    dout_ready = 1'b1;
    drive(1'b0, 1'b0);
    chk("ov_drained", {7'h0, dout_valid}, 8'h00);
    chk("ov_dout_kept", {4'h0, dout}, 8'h03);

    // Sparse strobes with glitches between them.
    send_frame(4'h6, 1'b0, 1'b0, 2, 1'b1);
    drive(1'b0, 1'b0);

    // Reset mid-frame after the 2nd data bit, then a clean 0x9 frame.
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    bit_en = 1'b0;
    rst    = 1'b1;
    #4;
    chk("midrst_flags", {3'h0, dout_valid, parity_err, frame_err, overrun, busy}, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #2;
    send_frame(4'h9, 1'b0, 1'b0, 0, 1'b1);
    chk("n9_dout", {4'h0, dout}, 8'h09);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 8'h00);
    chk("frame_err_count", fe_cnt, 8'h01);
    chk("overrun_count", ov_cnt, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
